// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Decides, each cycle, which pipeline registers (F/D/E/M/W) stall or flush.
// Events are ranked: MEM wait / MEM timeout, then MDU busy, then redirect,
// then load-use. Only the winning event acts; the others are re-evaluated on
// the next cycle.
//
// Parameters:
//   MEM_TIMEOUT  maximum MEM_WAIT-state cycles before the access is aborted
//                (1..255).
//
// Optional feature macro:
//   CTRL_PERF_CNT_EN  when defined, stall_cnt/redirect_cnt are live 32-bit
//                     wrapping counters; otherwise both ports read 0 and no
//                     counter flops exist.
//
// Ports:
//   clk                          sole clock, rising edge
//   rst                          asynchronous active-low reset
//   decode_i_rs1/_rs2 (+_ren)    ID source registers and read enables
//   regE_i_rd, regE_i_mem_read   EX destination register and load flag
//   exe_i_redirect               branch/jump taken in EX
//   exe_i_mdu_start, mdu_i_done  mul/div start pulse and completion
//   mem_i_req, mem_i_ready       MEM data access and acknowledge
//   ctrl_o_reg*_stall            hold the named pipeline register
//   ctrl_o_reg*_flash            flush the named pipeline register
//   ctrl_o_mem_err               one-cycle pulse after a MEM timeout abort
//   ctrl_o_state                 FSM state (0 RUN, 1 MDU_WAIT, 2 MEM_WAIT)
//   ctrl_o_stall_cnt             cycles with F stalled
//   ctrl_o_redirect_cnt          redirects acted upon
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  decode_i_rs1,
  input  logic [4:0]  decode_i_rs2,
  input  logic        decode_i_rs1_ren,
  input  logic        decode_i_rs2_ren,
  input  logic [4:0]  regE_i_rd,
  input  logic        regE_i_mem_read,
  input  logic        exe_i_redirect,
  input  logic        exe_i_mdu_start,
  input  logic        mdu_i_done,
  input  logic        mem_i_req,
  input  logic        mem_i_ready,
  output logic        ctrl_o_regF_stall,
  output logic        ctrl_o_regD_stall,
  output logic        ctrl_o_regE_stall,
  output logic        ctrl_o_regM_stall,
  output logic        ctrl_o_regD_flash,
  output logic        ctrl_o_regE_flash,
  output logic        ctrl_o_regM_flash,
  output logic        ctrl_o_regW_flash,
  output logic        ctrl_o_mem_err,
  output logic [1:0]  ctrl_o_state,
  output logic [31:0] ctrl_o_stall_cnt,
  output logic [31:0] ctrl_o_redirect_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // Counter value seen on the last allowed MEM_WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST_C = 8'(MEM_TIMEOUT - 1);

  state_e     state_r;
  state_e     state_nxt_s;
  logic [7:0] tcnt_r;
  logic       mem_err_r;

  logic in_run_s, in_mdu_s, in_mem_s;
  logic timeout_hit_s, memwait_s, mdubusy_s, loaduse_s;
  logic take_redirect_s;

  logic f_stall_s, d_stall_s, e_stall_s, m_stall_s;
  logic d_flash_s, e_flash_s, m_flash_s, w_flash_s;

  // One-hot view of the state; encoding 3 matches nothing and so behaves
  // like RUN without any event permitted to hold it there.
  always_comb begin
    in_run_s = 1'b0;
    in_mdu_s = 1'b0;
    in_mem_s = 1'b0;
    case (state_r)
      RUN:      in_run_s = 1'b1;
      MDU_WAIT: in_mdu_s = 1'b1;
      MEM_WAIT: in_mem_s = 1'b1;
      default: begin
        in_run_s = 1'b0;
        in_mdu_s = 1'b0;
        in_mem_s = 1'b0;
      end
    endcase
  end

  // Raw hazard conditions before prioritisation.
  always_comb begin
    timeout_hit_s = in_mem_s & (tcnt_r == TIMEOUT_LAST_C);
    memwait_s     = mem_i_req & ~mem_i_ready & ~timeout_hit_s;
    mdubusy_s     = (in_run_s & exe_i_mdu_start & ~mdu_i_done) |
                    (in_mdu_s & ~mdu_i_done);
    loaduse_s     = regE_i_mem_read & (regE_i_rd != 5'd0) &
                    ((decode_i_rs1_ren & (decode_i_rs1 == regE_i_rd)) |
                     (decode_i_rs2_ren & (decode_i_rs2 == regE_i_rd)));
  end

  // Priority resolution: exactly one event drives stalls/flushes and the
  // next state; a stalled register is never also flushed.
  always_comb begin
    f_stall_s       = 1'b0;
    d_stall_s       = 1'b0;
    e_stall_s       = 1'b0;
    m_stall_s       = 1'b0;
    d_flash_s       = 1'b0;
    e_flash_s       = 1'b0;
    m_flash_s       = 1'b0;
    w_flash_s       = 1'b0;
    take_redirect_s = 1'b0;
    state_nxt_s     = RUN;
    if (timeout_hit_s) begin
      // Abort: kill the MEM instruction and release the pipe.
      m_flash_s   = 1'b1;
      w_flash_s   = 1'b1;
      state_nxt_s = RUN;
    end else if (memwait_s) begin
      f_stall_s   = 1'b1;
      d_stall_s   = 1'b1;
      e_stall_s   = 1'b1;
      m_stall_s   = 1'b1;
      w_flash_s   = 1'b1;
      state_nxt_s = MEM_WAIT;
    end else if (mdubusy_s) begin
      f_stall_s   = 1'b1;
      d_stall_s   = 1'b1;
      e_stall_s   = 1'b1;
      m_flash_s   = 1'b1;
      state_nxt_s = MDU_WAIT;
    end else if (exe_i_redirect) begin
      d_flash_s       = 1'b1;
      e_flash_s       = 1'b1;
      take_redirect_s = 1'b1;
      state_nxt_s     = RUN;
    end else if (loaduse_s) begin
      // Hold the consumer in D and inject one bubble into E.
      f_stall_s   = 1'b1;
      d_stall_s   = 1'b1;
      e_flash_s   = 1'b1;
      state_nxt_s = RUN;
    end else begin
      state_nxt_s = RUN;
    end
  end

  // Output gating: reset holds every stall/flush low regardless of inputs.
  always_comb begin
    if (rst) begin
      ctrl_o_regF_stall = f_stall_s;
      ctrl_o_regD_stall = d_stall_s;
      ctrl_o_regE_stall = e_stall_s;
      ctrl_o_regM_stall = m_stall_s;
      ctrl_o_regD_flash = d_flash_s;
      ctrl_o_regE_flash = e_flash_s;
      ctrl_o_regM_flash = m_flash_s;
      ctrl_o_regW_flash = w_flash_s;
    end else begin
      ctrl_o_regF_stall = 1'b0;
      ctrl_o_regD_stall = 1'b0;
      ctrl_o_regE_stall = 1'b0;
      ctrl_o_regM_stall = 1'b0;
      ctrl_o_regD_flash = 1'b0;
      ctrl_o_regE_flash = 1'b0;
      ctrl_o_regM_flash = 1'b0;
      ctrl_o_regW_flash = 1'b0;
    end
  end

  // FSM state, MEM_WAIT cycle counter and registered timeout pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= RUN;
      tcnt_r    <= 8'd0;
      mem_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      mem_err_r <= timeout_hit_s;
      // Counter restarts at 0 on every entry and only advances while the
      // wait continues inside MEM_WAIT.
      if (in_mem_s && (state_nxt_s == MEM_WAIT)) begin
        tcnt_r <= tcnt_r + 8'd1;
      end else begin
        tcnt_r <= 8'd0;
      end
    end
  end

  assign ctrl_o_state   = state_r;
  assign ctrl_o_mem_err = mem_err_r;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] redirect_cnt_r;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r    <= 32'd0;
      redirect_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r    <= stall_cnt_r + {31'd0, f_stall_s};
      redirect_cnt_r <= redirect_cnt_r + {31'd0, take_redirect_s};
    end
  end

  assign ctrl_o_stall_cnt    = stall_cnt_r;
  assign ctrl_o_redirect_cnt = redirect_cnt_r;
`else
  logic unused_perf_s;
  assign unused_perf_s       = take_redirect_s;
  assign ctrl_o_stall_cnt    = 32'd0;
  assign ctrl_o_redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4).
// A behavioural model tracks the controller's mode and predicts every output
// on each falling edge; directed scenarios add hand-computed literal checks.
// Output vector order used throughout: {F_st, D_st, E_st, M_st, D_fl, E_fl,
// M_fl, W_fl}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic        ren1 = 1'b0, ren2 = 1'b0, mem_read = 1'b0;
  logic        redirect = 1'b0, start = 1'b0, done = 1'b0;
  logic        req = 1'b0, ready = 1'b0;
  logic        f_st, d_st, e_st, m_st, d_fl, e_fl, m_fl, w_fl, mem_err;
  logic [1:0]  state;
  logic [31:0] stall_cnt, redir_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: mode 0 RUN, 1 MDU wait, 2 MEM wait
  int          m_mode       = 0;
  int          m_mem_cycles = 0;
  logic        m_err        = 1'b0;
  logic [31:0] m_stall_cnt  = 32'd0;
  logic [31:0] m_redir_cnt  = 32'd0;

  hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .decode_i_rs1(rs1), .decode_i_rs2(rs2),
    .decode_i_rs1_ren(ren1), .decode_i_rs2_ren(ren2),
    .regE_i_rd(rd), .regE_i_mem_read(mem_read),
    .exe_i_redirect(redirect),
    .exe_i_mdu_start(start), .mdu_i_done(done),
    .mem_i_req(req), .mem_i_ready(ready),
    .ctrl_o_regF_stall(f_st), .ctrl_o_regD_stall(d_st),
    .ctrl_o_regE_stall(e_st), .ctrl_o_regM_stall(m_st),
    .ctrl_o_regD_flash(d_fl), .ctrl_o_regE_flash(e_fl),
    .ctrl_o_regM_flash(m_fl), .ctrl_o_regW_flash(w_fl),
    .ctrl_o_mem_err(mem_err), .ctrl_o_state(state),
    .ctrl_o_stall_cnt(stall_cnt), .ctrl_o_redirect_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {f_st, d_st, e_st, m_st, d_fl, e_fl, m_fl, w_fl};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; ren1 = 1'b0; ren2 = 1'b0;
    mem_read = 1'b0; redirect = 1'b0; start = 1'b0; done = 1'b0;
    req = 1'b0; ready = 1'b0;
  endtask

  // Model: predict outputs from the priority rules, compare, then advance.
  always @(negedge clk) begin : model
    logic [7:0]  e;
    logic [31:0] exp_sc, exp_rc;
    int          nmode, ncyc;
    logic        nerr, blocked, lu;
    e = 8'd0; nmode = 0; ncyc = 0; nerr = 1'b0;
    if (!rst) begin
      m_mode = 0; m_mem_cycles = 0; m_err = 1'b0;
      m_stall_cnt = 32'd0; m_redir_cnt = 32'd0;
    end
    blocked = req && !ready;
    lu = mem_read && (rd != 5'd0) && ((ren1 && rs1 == rd) || (ren2 && rs2 == rd));
    if (!rst) e = 8'd0;
    else if (m_mode == 2 && m_mem_cycles + 1 == MT) begin e = 8'b0000_0011; nerr = 1'b1; end
    else if (blocked) begin
      e = 8'b1111_0001; nmode = 2;
      ncyc = (m_mode == 2) ? m_mem_cycles + 1 : 0;
    end
    else if ((m_mode == 0 && start && !done) || (m_mode == 1 && !done)) begin
      e = 8'b1110_0010; nmode = 1;
    end
    else if (redirect) e = 8'b0000_1100;
    else if (lu) e = 8'b1100_0100;
    else e = 8'd0;
`ifdef CTRL_PERF_CNT_EN
    exp_sc = m_stall_cnt; exp_rc = m_redir_cnt;
`else
    exp_sc = 32'd0; exp_rc = 32'd0;
`endif
    chk("model_outs", {24'd0, outs()}, {24'd0, e});
    chk("model_state", {30'd0, state}, 32'(m_mode));
    chk("model_mem_err", {31'd0, mem_err}, {31'd0, m_err});
    chk("model_stall_cnt", stall_cnt, exp_sc);
    chk("model_redir_cnt", redir_cnt, exp_rc);
    if (rst) begin
      m_stall_cnt = m_stall_cnt + {31'd0, e[7]};
      if (e == 8'b0000_1100) m_redir_cnt = m_redir_cnt + 32'd1;
      m_mode = nmode; m_mem_cycles = ncyc; m_err = nerr;
    end
  end

  initial begin
    clear_inputs();
    // Reset state, with inputs that would otherwise cause a hazard.
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; req = 1'b1;
    #1;
    chk("reset_outs", {24'd0, outs()}, 32'd0);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_cnt", stall_cnt | redir_cnt, 32'd0);
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();

    // Load-use: rd=5 load in EX, rs1=5 read in ID.
    rd = 5'd5; mem_read = 1'b1; rs1 = 5'd5; ren1 = 1'b1;
    #1 chk("loaduse", {24'd0, outs()}, 32'b1100_0100);
    tick();
    mem_read = 1'b0;
    #1 chk("after_loaduse", {24'd0, outs()}, 32'd0);
    tick();
    rd = 5'd0; rs1 = 5'd0; mem_read = 1'b1;
    #1 chk("loaduse_rd0", {24'd0, outs()}, 32'd0);
    rd = 5'd9; rs2 = 5'd9; ren1 = 1'b0; ren2 = 1'b0;
    #1 chk("loaduse_no_ren", {24'd0, outs()}, 32'd0);
    ren2 = 1'b1;
    #1 chk("loaduse_rs2", {24'd0, outs()}, 32'b1100_0100);
    tick();
    clear_inputs();
    tick();

    // MDU: start, done arrives four cycles later.
    start = 1'b1;
    #1 chk("mdu_start", {24'd0, outs()}, 32'b1110_0010);
    tick();
    start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1 chk("mdu_wait", {24'd0, outs()}, 32'b1110_0010);
      chk("mdu_state", {30'd0, state}, 32'd1);
      tick();
    end
    done = 1'b1;
    #1 chk("mdu_done", {24'd0, outs()}, 32'd0);
    tick();
    done = 1'b0;
    #1 chk("mdu_back_run", {30'd0, state}, 32'd0);
    start = 1'b1; done = 1'b1;
    #1 chk("mdu_start_done", {24'd0, outs()}, 32'd0);
    tick();
    clear_inputs();
    tick();

    // MEM: ready low for 3 cycles, released on the ready cycle.
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mem_wait", {24'd0, outs()}, 32'b1111_0001);
      tick();
    end
    ready = 1'b1;
    #1 chk("mem_release", {24'd0, outs()}, 32'd0);
    tick();
    clear_inputs();
    tick();

    // MEM timeout with MEM_TIMEOUT=4: abort on the 4th MEM_WAIT-state cycle.
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("to_wait", {24'd0, outs()}, 32'b1111_0001);
      tick();
    end
    #1 chk("to_abort_outs", {24'd0, outs()}, 32'b0000_0011);
    chk("to_abort_state", {30'd0, state}, 32'd2);
    chk("to_abort_err", {31'd0, mem_err}, 32'd0);
    tick();
    req = 1'b0;
    #1 chk("to_err_pulse", {31'd0, mem_err}, 32'd1);
    chk("to_state_run", {30'd0, state}, 32'd0);
    tick();
    #1 chk("to_err_low", {31'd0, mem_err}, 32'd0);
    tick();

    // Redirect together with load-use: flush only, first redirect counted.
    rd = 5'd7; mem_read = 1'b1; rs2 = 5'd7; ren2 = 1'b1; redirect = 1'b1;
    #1 chk("redir_lu", {24'd0, outs()}, 32'b0000_1100);
    tick();
    clear_inputs();
`ifdef CTRL_PERF_CNT_EN
    #1 chk("redir_cnt_one", redir_cnt, 32'd1);
`else
    #1 chk("redir_cnt_tied", redir_cnt, 32'd0);
`endif
    tick();

    // Priority: MDU over redirect, MEM over MDU.
    start = 1'b1; redirect = 1'b1;
    #1 chk("prio_mdu_redir", {24'd0, outs()}, 32'b1110_0010);
    tick();
    start = 1'b0; redirect = 1'b0; done = 1'b1;
    tick();
    done = 1'b0; req = 1'b1; start = 1'b1;
    #1 chk("prio_mem_mdu", {24'd0, outs()}, 32'b1111_0001);
    tick();
    start = 1'b0; ready = 1'b1;
    #1 chk("prio_mem_release", {24'd0, outs()}, 32'd0);
    tick();
    clear_inputs();
    tick();

    // Reset dropped in the middle of MDU_WAIT.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1 chk("pre_rst_state", {30'd0, state}, 32'd1);
    rst = 1'b0;
    #1 chk("async_rst_outs", {24'd0, outs()}, 32'd0);
    chk("async_rst_state", {30'd0, state}, 32'd0);
    chk("async_rst_cnt", stall_cnt | redir_cnt, 32'd0);
    tick();
    rst = 1'b1;
    #1 chk("post_rst_outs", {24'd0, outs()}, 32'd0);
    tick();
    #1 chk("post_rst_err", {31'd0, mem_err}, 32'd0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of MEM_WAIT cycles before abort (range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all flops on posedge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports decode_i_rs1, decode_i_rs2  in  5 each  ID source register indices.
REQ-005 SHALL have ports decode_i_rs1_ren, decode_i_rs2_ren  in  1 each  source actually read.
REQ-006 SHALL have ports regE_i_rd  in  5, regE_i_mem_read  in  1  EX-stage destination and load flag.
REQ-007 SHALL have port exe_i_redirect  in  1  branch/jump taken in EX.
REQ-008 SHALL have ports exe_i_mdu_start  in  1, mdu_i_done  in  1  mul/div start pulse and completion.
REQ-009 SHALL have ports mem_i_req  in  1, mem_i_ready  in  1  MEM-stage data access and acknowledge.
REQ-010 SHALL have outputs ctrl_o_regF_stall, ctrl_o_regD_stall, ctrl_o_regE_stall and ctrl_o_regM_stall  out  1 each.
REQ-011 SHALL have outputs ctrl_o_regD_flash, ctrl_o_regE_flash, ctrl_o_regM_flash and ctrl_o_regW_flash  out  1 each.
REQ-012 SHALL have outputs ctrl_o_mem_err  out  1  timeout pulse, and ctrl_o_state  out  2  FSM state.
REQ-013 SHALL have outputs ctrl_o_stall_cnt and ctrl_o_redirect_cnt  out  32 each  performance counters.

Function
REQ-014 SHALL implement FSM states RUN=0, MDU_WAIT=1, MEM_WAIT=2; the encoding 3 SHALL be unreachable and SHALL return to RUN.
REQ-015 SHALL define memwait = mem_i_req & ~mem_i_ready & ~timeout_hit; it SHALL stall F, D, E and M, assert regW_flash, and go to or stay in MEM_WAIT.
REQ-016 SHALL count MEM_WAIT cycles with an 8-bit counter cleared on entry; when count == MEM_TIMEOUT-1 (timeout_hit), it SHALL pulse ctrl_o_mem_err one cycle, assert regM_flash and regW_flash, assert no stalls, and go to RUN.
REQ-017 SHALL leave MEM_WAIT with no stalls in the same cycle that mem_i_ready=1 (zero added latency).
REQ-018 SHALL define mdubusy = (RUN & exe_i_mdu_start & ~mdu_i_done) | (MDU_WAIT & ~mdu_i_done); it SHALL stall F, D and E, assert regM_flash, and go to or stay in MDU_WAIT.
REQ-019 SHALL produce no stall when start and done are both high in the same cycle; MDU_WAIT SHALL go to RUN in the cycle done=1.
REQ-020 SHALL, on redirect (exe_i_redirect, not masked), assert regD_flash and regE_flash, assert no stalls, and increment redirect_cnt.
REQ-021 SHALL define loaduse = regE_i_mem_read & rd!=0 & ((rs1_ren & rs1==rd) | (rs2_ren & rs2==rd)); it SHALL stall F and D and assert regE_flash for exactly one cycle.
REQ-022 SHALL resolve simultaneous events in this priority: memwait/timeout > mdubusy > redirect > loaduse; a lower-priority event SHALL be ignored that cycle and re-evaluated the next cycle.
REQ-023 SHALL never assert a stall and a flash for the same register in one cycle.
REQ-024 SHALL generate all stall and flash outputs combinationally from the current state and inputs; state, counter and mem_err SHALL be registered.

Reset
REQ-025 SHALL, while rst=0, immediately force state=RUN, the timeout counter to 0, ctrl_o_mem_err=0 and both perf counters to 0.
REQ-026 SHALL, while rst=0, force all stall and flash outputs to 0.
REQ-027 SHALL, on a reset asserted during MDU_WAIT or MEM_WAIT, abandon the wait with no pulse on exit.

Configuration
REQ-028 SHALL, with CTRL_PERF_CNT_EN defined, increment stall_cnt each cycle regF_stall=1 and redirect_cnt per REQ-020; both SHALL wrap at 2^32.
REQ-029 SHALL, without CTRL_PERF_CNT_EN, keep both counter ports present, tie them to 0, and instantiate no counter flops.

Verification
REQ-030 SHALL cover: rd=5 load in EX, rs1=5 with ren=1 -> one cycle of F/D stall and E flash, then normal flow.
REQ-031 SHALL cover: mdu_start, with done arriving 4 cycles later -> F/D/E stall and M flash for 4 cycles, state=1, then RUN.
REQ-032 SHALL cover: mem_req with ready low for 3 cycles -> F/D/E/M stall and W flash for 3 cycles, released on the ready cycle.
REQ-033 SHALL cover: MEM_TIMEOUT=4 and ready never high -> mem_err pulses on the 4th MEM_WAIT cycle, M/W flash, state=0.
REQ-034 SHALL cover: redirect together with load-use -> D/E flash only, no stall, and redirect_cnt +1 with CTRL_PERF_CNT_EN defined.
REQ-035 SHALL cover: rst dropped mid-MDU_WAIT -> all outputs 0 and state=0 asynchronously.
